// File: rtl/ifu_pc_pkg.sv
// rtl/ifu_pc_pkg.sv - shared constants, types and helpers for the fetch PC unit
package ifu_pc_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] NOP_INSTR        = '0;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [WORD_W-1:0] PC_STEP          = 32'd4;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/ifu_pc_if_id_reg.sv
// rtl/ifu_pc_if_id_reg.sv - IF/ID pipeline register with load-enable and squash
module if_id_reg
  import ifu_pc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              squash_i,
  input  logic              valid_i,
  input  logic [WORD_W-1:0] instr_i,
  input  logic [WORD_W-1:0] pcadd4_i,
  output logic [WORD_W-1:0] instr_o,
  output logic [WORD_W-1:0] pcadd4_o,
  output logic              valid_o
);

  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pcadd4_q, pcadd4_d;
  logic              valid_q, valid_d;

  // pcadd4 is loaded even on squash; ID ignores it while valid is low
  always_comb begin
    instr_d  = instr_q;
    pcadd4_d = pcadd4_q;
    valid_d  = valid_q;
    if (load_i) begin
      pcadd4_d = pcadd4_i;
      if (squash_i) begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end else begin
        instr_d = instr_i;
        valid_d = valid_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q  <= NOP_INSTR;
      pcadd4_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      instr_q  <= instr_d;
      pcadd4_q <= pcadd4_d;
      valid_q  <= valid_d;
    end
  end

  assign instr_o  = instr_q;
  assign pcadd4_o = pcadd4_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/ifu_pc.sv
// rtl/ifu_pc.sv - fetch PC register, next-PC mux, boot FSM and IF/ID load
module ifu_pc
  import ifu_pc_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter bit                DELAY_SLOT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              pc_sel,
  input  logic [WORD_W-1:0] bj_npc,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] if_id_instr,
  output logic [WORD_W-1:0] if_id_pcadd4,
  output logic              if_id_valid,
  output logic              exc_misalign
);

  fetch_state_e state_q, state_d;

  logic [WORD_W-1:0] pc_q, pc_d;
  logic              exc_q, exc_d;
  logic [WORD_W-1:0] pcadd4;
  logic              advance;
  logic              redirect;
  logic              squash;
  logic              fetch_valid;

  assign pcadd4   = pc_q + PC_STEP;
  assign advance  = !stall;
  // A stalled ID re-presents its redirect, so pc_sel only counts on a moving edge
  assign redirect = advance && pc_sel;
  assign squash   = (DELAY_SLOT == 1'b0) && redirect;

  always_comb begin
    state_d     = state_q;
    fetch_valid = 1'b1;
    unique case (state_q)
      ST_BOOT: begin
        fetch_valid = advance;
        if (advance) state_d = ST_RUN;
      end
      ST_RUN: begin
        fetch_valid = 1'b1;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    exc_d = exc_q;
    if (redirect) begin
      pc_d = align_word(bj_npc);
      if (is_misaligned(bj_npc)) exc_d = 1'b1;
    end else if (advance) begin
      pc_d = pcadd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      exc_q   <= exc_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (advance),
    .squash_i (squash),
    .valid_i  (fetch_valid),
    .instr_i  (imem_rdata),
    .pcadd4_i (pcadd4),
    .instr_o  (if_id_instr),
    .pcadd4_o (if_id_pcadd4),
    .valid_o  (if_id_valid)
  );

  assign pc           = pc_q;
  assign exc_misalign = exc_q;

endmodule

// File: tb/tb_ifu_pc.sv
// tb/tb_ifu_pc.sv - self-checking bench for ifu_pc in both delay-slot modes
module tb_ifu_pc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        pc_sel;
  logic [31:0] bj_npc;
  logic [31:0] imem_rdata [2];
  logic [31:0] pc         [2];
  logic [31:0] if_id_instr[2];
  logic [31:0] if_id_pcadd4[2];
  logic        if_id_valid[2];
  logic        exc_misalign[2];

  int tests = 0;
  int fails = 0;

  // expected architectural state, index 0 = no delay slot, 1 = delay slot
  logic [31:0] m_pc[2], m_instr[2], m_pcadd4[2];
  logic        m_valid[2], m_exc[2];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2008_0005;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata[0] = mem(pc[0]);
  assign imem_rdata[1] = mem(pc[1]);

  ifu_pc #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1'b0)) u_dut_ns (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc_sel(pc_sel), .bj_npc(bj_npc),
    .imem_rdata(imem_rdata[0]), .pc(pc[0]), .if_id_instr(if_id_instr[0]),
    .if_id_pcadd4(if_id_pcadd4[0]), .if_id_valid(if_id_valid[0]),
    .exc_misalign(exc_misalign[0])
  );

  ifu_pc #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1'b1)) u_dut_ds (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc_sel(pc_sel), .bj_npc(bj_npc),
    .imem_rdata(imem_rdata[1]), .pc(pc[1]), .if_id_instr(if_id_instr[1]),
    .if_id_pcadd4(if_id_pcadd4[1]), .if_id_valid(if_id_valid[1]),
    .exc_misalign(exc_misalign[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pc[d] = 32'h0000_3000; m_instr[d] = 32'h0; m_pcadd4[d] = 32'h0;
      m_valid[d] = 1'b0; m_exc[d] = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s[ds=%0d].pc", tag, d), pc[d], m_pc[d]);
      chk($sformatf("%s[ds=%0d].instr", tag, d), if_id_instr[d], m_instr[d]);
      chk($sformatf("%s[ds=%0d].pcadd4", tag, d), if_id_pcadd4[d], m_pcadd4[d]);
      chk($sformatf("%s[ds=%0d].valid", tag, d), {31'b0, if_id_valid[d]}, {31'b0, m_valid[d]});
      chk($sformatf("%s[ds=%0d].exc", tag, d), {31'b0, exc_misalign[d]}, {31'b0, m_exc[d]});
    end
  endtask

  // one clock: drive at negedge, predict, check 1 time unit after posedge, return at negedge
  task automatic step(input string tag, input logic s, input logic p, input logic [31:0] t);
    stall = s; pc_sel = p; bj_npc = t;
    for (int d = 0; d < 2; d++) begin
      if (!s) begin
        logic [31:0] fetched;
        logic [31:0] next_seq;
        fetched  = mem(m_pc[d]);
        next_seq = m_pc[d] + 32'd4;
        m_pcadd4[d] = next_seq;
        if (p && d == 0) begin
          m_instr[d] = 32'h0; m_valid[d] = 1'b0;
        end else begin
          m_instr[d] = fetched; m_valid[d] = 1'b1;
        end
        if (p) begin
          m_pc[d] = t & 32'hFFFF_FFFC;
          if (t % 4 != 0) m_exc[d] = 1'b1;
        end else begin
          m_pc[d] = next_seq;
        end
      end
    end
    @(posedge clk); #1;
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1; stall = 1'b0; pc_sel = 1'b0; bj_npc = 32'h0;
    model_reset();

    // reset asserted mid-cycle takes effect immediately
    #2 rst_n = 1'b0;
    #1 check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step("boot_fetch", 1'b0, 1'b0, 32'h0);
    chk("boot_instr_const", if_id_instr[1], 32'h2008_0005);
    chk("boot_pcadd4_const", if_id_pcadd4[1], 32'h0000_3004);
    step("seq1", 1'b0, 1'b0, 32'h0);
    chk("seq_pc_3008", pc[1], 32'h0000_3008);

    // stall with a pending redirect: everything frozen
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b1, 32'h0000_3100);
    chk("stall_pc_hold", pc[0], 32'h0000_3008);
    step("stall_release", 1'b0, 1'b1, 32'h0000_3100);
    chk("stall_release_pc", pc[0], 32'h0000_3100);

    step("to_3010", 1'b0, 1'b1, 32'h0000_3010);
    step("redir_3040", 1'b0, 1'b1, 32'h0000_3040);
    chk("ds1_slot_valid", {31'b0, if_id_valid[1]}, 32'd1);
    chk("ds0_squash_instr", if_id_instr[0], 32'h0);
    step("target_fetch", 1'b0, 1'b0, 32'h0);
    chk("target_instr", if_id_instr[0], mem(32'h0000_3040));

    step("misalign", 1'b0, 1'b1, 32'h0000_3042);
    chk("misalign_pc", pc[0], 32'h0000_3040);
    step("aligned_after", 1'b0, 1'b1, 32'h0000_3080);
    chk("misalign_sticky", {31'b0, exc_misalign[1]}, 32'd1);
    step("b2b_redirect", 1'b0, 1'b1, 32'h0000_4000);

    step("wrap_redir", 1'b0, 1'b1, 32'hFFFF_FFFC);
    step("wrap_seq", 1'b0, 1'b0, 32'h0);
    chk("wrap_pc", pc[1], 32'h0);
    chk("wrap_pcadd4", if_id_pcadd4[1], 32'h0);
    step("post_wrap", 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 200; i++) begin
      logic        s, p;
      logic [31:0] t;
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 4) == 0);
      t = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
      step("rand", s, p, t);
    end

    // asynchronous reset mid-stall with a redirect pending
    stall = 1'b1; pc_sel = 1'b1; bj_npc = 32'h0000_5002;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("after_reset_stalled", 1'b1, 1'b0, 32'h0);
    step("after_reset_fetch", 1'b0, 1'b0, 32'h0);
    step("after_reset_seq", 1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ifu_pc.md
Name: ifu_pc

Overview:
- Fetch-side partner of the next-PC logic. Owns the PC register and drives the instruction-memory address.
- Consumes the redirect pair (taken flag plus target) produced in ID. Loads the IF/ID pipeline register with the fetched instruction and PC+4.
- The PC+4 it produces is the value the ID stage uses to compute branch targets. This closes the loop between IF and ID.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- DELAY_SLOT, 1. When 1, the instruction after a branch or jump executes (MIPS delay slot). When 0, a taken redirect squashes the IF/ID entry.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- stall, input, 1, hazard-unit freeze; holds PC and IF/ID.
- pc_sel, input, 1, redirect request from ID (taken branch, j/jal, jr).
- bj_npc, input, 32, redirect target from ID.
- imem_rdata, input, 32, instruction word at pc; combinational read.
- pc, output, 32, current fetch address to instruction memory.
- if_id_instr, output, 32, registered instruction for ID.
- if_id_pcadd4, output, 32, registered PC+4 of that instruction.
- if_id_valid, output, 1, IF/ID holds a real instruction.
- exc_misalign, output, 1, sticky flag: a redirect target had bj_npc[1:0] != 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC.
  - if_id_instr = 32'h0000_0000 (nop).
  - if_id_pcadd4 = 0.
  - if_id_valid = 0.
  - exc_misalign = 0.
- Release from reset: first fetch at RESET_PC on the first rising edge after rst_n goes high.
- pcadd4 = pc + 32'd4, 32-bit modulo arithmetic. 32'hFFFF_FFFC wraps to 0 with no flag.
- Next-PC priority, evaluated each rising edge:
  1. stall = 1: pc, if_id_instr, if_id_pcadd4 and if_id_valid all hold. pc_sel is ignored, because ID is frozen and re-presents the redirect next cycle.
  2. pc_sel = 1: pc <= {bj_npc[31:2], 2'b00}. If bj_npc[1:0] != 0, exc_misalign <= 1; it stays set until reset.
  3. Otherwise: pc <= pcadd4.
- IF/ID load when stall = 0:
  - if_id_instr <= imem_rdata.
  - if_id_pcadd4 <= pcadd4.
  - if_id_valid <= 1.
- DELAY_SLOT = 0 with pc_sel = 1 and stall = 0: the wrong-path fetch is squashed.
  - if_id_instr <= 0, if_id_valid <= 0.
  - if_id_pcadd4 is still loaded (don't-care).
- DELAY_SLOT = 1: no squash; the fetched word is the delay-slot instruction.
- Latency:
  - Redirect taken on edge N puts the target on pc after edge N.
  - The target instruction appears in IF/ID after edge N+1.
  - Fetch throughput is one instruction per cycle when not stalled.
- Back-to-back redirects on consecutive cycles each take effect; there is no internal queue.
- Reset mid-stall or mid-redirect: reset wins immediately; no pending state survives.
- pc_sel high while stall is high, then stall drops: the redirect is honoured on the first unstalled edge only if pc_sel is still high.
- State machine, 2 states, controlling if_id_valid:
  - BOOT: after reset, until the first unstalled edge.
  - RUN: normal fetch.
  - In BOOT, IF/ID stays invalid until the first load.
  - BOOT -> RUN on the first edge with stall = 0. RUN is left only via reset.
- No output is combinationally dependent on stall or pc_sel; pc and all IF/ID outputs are registers.

Decomposition:
- Shared package:
  - NOP_INSTR = 32'h0.
  - RESET_PC default.
  - Width constant WORD_W = 32.
- One sub-module, if_id_reg: the IF/ID pipeline register with load-enable and squash inputs. It holds instr, pcadd4 and valid with the same reset values.
- ifu_pc instantiates if_id_reg and keeps the PC register, next-PC mux and BOOT/RUN FSM itself.

Test Plan:
- Reset/boot: assert rst_n = 0 mid-cycle, release, imem returns 32'h2008_0005 at 0x3000.
  - pc = 0x3000 immediately on reset; if_id_valid = 0.
  - After edge 1: if_id_instr = 32'h2008_0005, if_id_pcadd4 = 0x3004, pc = 0x3004.
- Sequential fetch over 4 edges with no stall and no redirect:
  - pc = 0x3004, 0x3008, 0x300C, 0x3010.
  - if_id_pcadd4 trails pc by one cycle.
- Stall: stall = 1 for 3 edges at pc = 0x3008 with pc_sel = 1, bj_npc = 0x3100.
  - pc stays 0x3008 and IF/ID is frozen throughout; the redirect is ignored.
  - Drop stall with pc_sel still 1: pc = 0x3100.
- Redirect at pc = 0x3010, bj_npc = 0x3040:
  - DELAY_SLOT = 1: IF/ID gets the 0x3010 word with valid = 1, then the 0x3040 word.
  - DELAY_SLOT = 0: IF/ID valid = 0 and instr = 0, then the 0x3040 word.
- Misaligned redirect to 0x3042: pc = 0x3040 and exc_misalign = 1. It stays 1 after a later aligned redirect and clears only on rst_n = 0.
- Wrap-around: drive redirect to 0xFFFF_FFFC, then no redirect. Next pc = 0x0000_0000 and if_id_pcadd4 = 0.
